axil_cfg_sequencer: RTL and testbench
=====================================

// Module: axil_cfg_sequencer
// PURPOSE
//  Single-outstanding AXI4-Lite master engine that turns simple register commands into AW/W/B or AR/R transactions.
//  Sits between the configuration/control logic and axi_lite_slave-class register blocks (4 x 32-bit, byte-strobed).
//  Sequences one access at a time and returns read data and completion status on a one-cycle response strobe.
// PARAMETERS
//  ADDR_WIDTH      4    AXI address width; cmd_addr passed through unmodified
//  DATA_WIDTH      32   data width; strobe width is DATA_WIDTH/8
//  TIMEOUT_CYCLES  256  watchdog limit, cycles from command accept (used only with AXIL_TIMEOUT_EN)
// PORTS
//  ACLK       in   1      clock; all logic on the rising edge
//  ARESETn    in   1      asynchronous, active-low reset
//  cmd_valid  in   1      command request
//  cmd_ready  out  1      engine idle; command accepted when cmd_valid & cmd_ready
//  cmd_write  in   1      1 = write, 0 = read
//  cmd_addr   in   ADDR_WIDTH      target byte address
//  cmd_wdata  in   DATA_WIDTH      write data
//  cmd_wstrb  in   DATA_WIDTH/8    write byte strobes
//  rsp_valid  out  1      one-cycle completion strobe
//  rsp_rdata  out  DATA_WIDTH      read data; valid with rsp_valid on reads, 0 on writes
//  rsp_err    out  1      access timed out (always 0 without AXIL_TIMEOUT_EN)
//  m_awaddr / m_awvalid out, m_awready in          write address channel
//  m_wdata, m_wstrb / m_wvalid out, m_wready in    write data channel
//  m_bvalid in, m_bready out                       write response channel
//  m_araddr / m_arvalid out, m_arready in          read address channel
//  m_rdata / m_rvalid in, m_rready out             read data channel
// BEHAVIOUR
//  Reset: state IDLE; every output 0, including cmd_ready.
//  First edge after reset release: cmd_ready = 1.
//  All outputs registered.
//  FSM: IDLE -> WR_REQ -> WR_RESP -> RSP -> IDLE, or IDLE -> RD_REQ -> RD_DATA -> RSP -> IDLE.
//  IDLE: cmd_ready = 1. On accept, latch addr/wdata/wstrb, drop cmd_ready, assert valids on the next edge.
//  WR_REQ: m_awvalid and m_wvalid rise together. Each drops on the edge of its own handshake; aw_done/w_done flags track them.
//   Once both flags are set -> WR_RESP with m_bready = 1.
//   Address and data stay stable while the corresponding valid is high.
//  WR_RESP: on m_bvalid & m_bready, drop m_bready -> RSP.
//  RD_REQ: m_arvalid held until m_arready, then -> RD_DATA with m_rready = 1.
//  RD_DATA: on m_rvalid & m_rready, capture m_rdata into rsp_rdata, drop m_rready -> RSP.
//  RSP: rsp_valid = 1 for exactly one cycle; cmd_ready returns to 1 on the following edge.
//   No back-to-back accept in the RSP cycle.
//  A valid is never deasserted before its handshake (no timeout configured).
//  Slave ready may arrive any number of cycles later.
//  cmd_* inputs are ignored while cmd_ready = 0.
//  An async reset mid-transaction aborts immediately, with no response; the in-flight access is lost.
// CONFIGURATION
//  AXIL_TIMEOUT_EN defined: a 16-bit counter clears on accept and increments in every non-IDLE/non-RSP state.
//   On reaching TIMEOUT_CYCLES, all m_*valid/m_*ready drop and the FSM goes to RSP with rsp_err = 1, rsp_rdata = 0.
//   Late slave beats are ignored in IDLE.
//  Undefined: no counter; the FSM waits indefinitely; rsp_err tied 0.
// STRUCTURE
//  Package axil_seq_pkg: seq_state_e enum; AXI_RESP_OKAY constant; strobe-width localparam.
//  Sub-module axil_seq_watchdog (load/inc/expire counter), instantiated only under AXIL_TIMEOUT_EN.
// TESTING (bench instantiates axi_lite_slave as the target)
//  1. Write 0xDEADBEEF, strb 0xF, addr 0x4, then read 0x4 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, one rsp_valid pulse per command.
//  2. Write 0xFFFFFFFF to 0x8, then 0x00001234 with strb 0x3 -> read 0x8 returns 0xFFFF1234.
//  3. Hold cmd_valid high across 4 writes -> exactly 4 accepts, cmd_ready low from accept through RSP, AW/W never overlap two commands.
//  4. Assert ARESETn low while in WR_RESP -> all outputs 0 the same cycle; cmd_ready = 1 one edge after release; no rsp_valid.
//  5. AXIL_TIMEOUT_EN, TIMEOUT_CYCLES = 16, stub slave that never raises m_awready ->
//     rsp_valid with rsp_err = 1 sixteen cycles after accept; m_awvalid/m_wvalid low.
//  6. Read of an unwritten register after reset -> completes with rsp_err = 0 and rsp_rdata checked only for X-free.

Source files
------------

// File: rtl/axil_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axil_seq_pkg
//  Purpose  : Shared types and constants for the AXI4-Lite config sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package axil_seq_pkg;

  // Sequencer FSM states; one access in flight at a time.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } seq_state_e;

  // AXI response code for a successful access.
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Native data width of the targeted register blocks and its strobe width.
  localparam int unsigned SEQ_DATA_WIDTH = 32;
  localparam int unsigned SEQ_STRB_WIDTH = SEQ_DATA_WIDTH / 8;

endpackage
`default_nettype wire

// File: rtl/axil_seq_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : axil_seq_watchdog
//  Purpose  : Load/increment counter that flags an access exceeding LIMIT
//             cycles. Built only when AXIL_TIMEOUT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module axil_seq_watchdog #(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned LIMIT     = 256
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic load_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(LIMIT - 1);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Clear on command accept, count every busy cycle, saturate at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the busy cycle whose increment would reach LIMIT, so the
  // sequencer lands in its response state exactly LIMIT cycles after accept.
  assign expire_o = inc_i && (cnt_q == LAST_COUNT);

endmodule
`default_nettype wire

// File: rtl/axil_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : axil_cfg_sequencer
//  Purpose  : Single-outstanding AXI4-Lite master; turns register commands
//             into AW/W/B or AR/R transactions and returns a one-cycle
//             response strobe. All outputs are registered.
//  Options  : AXIL_TIMEOUT_EN - enables the access watchdog (rsp_err_o).
//  Revision : 1.0 - initial release
// ============================================================================
module axil_cfg_sequencer
  import axil_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned DATA_WIDTH     = SEQ_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  // Command side
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,
  // Response side
  output logic                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  // AXI4-Lite write address / data / response
  output logic [ADDR_WIDTH-1:0]   m_awaddr_o,
  output logic                    m_awvalid_o,
  input  logic                    m_awready_i,
  output logic [DATA_WIDTH-1:0]   m_wdata_o,
  output logic [DATA_WIDTH/8-1:0] m_wstrb_o,
  output logic                    m_wvalid_o,
  input  logic                    m_wready_i,
  input  logic                    m_bvalid_i,
  output logic                    m_bready_o,
  // AXI4-Lite read address / data
  output logic [ADDR_WIDTH-1:0]   m_araddr_o,
  output logic                    m_arvalid_o,
  input  logic                    m_arready_i,
  input  logic [DATA_WIDTH-1:0]   m_rdata_i,
  input  logic                    m_rvalid_i,
  output logic                    m_rready_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  seq_state_e              state_q,     state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q,     wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q,     wstrb_d;
  logic                    awvalid_q,   awvalid_d;
  logic                    wvalid_q,    wvalid_d;
  logic                    aw_done_q,   aw_done_d;
  logic                    w_done_q,    w_done_d;
  logic                    bready_q,    bready_d;
  logic                    arvalid_q,   arvalid_d;
  logic                    rready_q,    rready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q,   rsp_err_d;

  logic                    w_expire;

`ifdef AXIL_TIMEOUT_EN
  logic w_accept;
  logic w_busy;

  assign w_accept = (state_q == ST_IDLE) && cmd_valid_i && cmd_ready_q;
  assign w_busy   = (state_q != ST_IDLE) && (state_q != ST_RSP);

  axil_seq_watchdog #(
    .CNT_WIDTH (16),
    .LIMIT     (TIMEOUT_CYCLES)
  ) u_watchdog (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .load_i   (w_accept),
    .inc_i    (w_busy),
    .expire_o (w_expire)
  );
`else
  // No watchdog: accesses wait for the slave indefinitely.
  logic w_unused_tmo;
  assign w_unused_tmo = |TIMEOUT_CYCLES;
  assign w_expire     = 1'b0;
`endif

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        // cmd_ready_q gates acceptance so the reset-exit cycle takes nothing.
        if (cmd_valid_i && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr_i;
          wdata_d     = cmd_wdata_i;
          wstrb_d     = cmd_wstrb_i;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          if (cmd_write_i) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = ST_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_REQ;
          end
        end
      end

      ST_WR_REQ: begin
        if (awvalid_q && m_awready_i) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && m_wready_i) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // Use the updated flags so the last handshake moves straight on.
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end

      ST_WR_RESP: begin
        if (m_bvalid_i && bready_q) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end
      end

      ST_RD_REQ: begin
        if (arvalid_q && m_arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        if (m_rvalid_i && rready_q) begin
          rready_d    = 1'b0;
          rsp_rdata_d = m_rdata_i;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end
      end

      ST_RSP: begin
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Watchdog expiry abandons the access: release the bus, report error.
    if (w_expire) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b1;
      rsp_valid_d = 1'b1;
      state_d     = ST_RSP;
    end
  end

  // State and output registers; async reset drops every output at once.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign m_awaddr_o  = addr_q;
  assign m_awvalid_o = awvalid_q;
  assign m_wdata_o   = wdata_q;
  assign m_wstrb_o   = wstrb_q;
  assign m_wvalid_o  = wvalid_q;
  assign m_bready_o  = bready_q;
  assign m_araddr_o  = addr_q;
  assign m_arvalid_o = arvalid_q;
  assign m_rready_o  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_cfg_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_axil_cfg_sequencer
//  Purpose  : Scoreboard bench for axil_cfg_sequencer with a 4 x 32-bit
//             byte-strobed AXI4-Lite register slave with random ready delays.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axil_cfg_sequencer;

  localparam int TMO = 16;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  m_awaddr, m_araddr, m_wstrb;
  logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [31:0] m_wdata;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [31:0] rdata;

  axil_cfg_sequencer #(
    .ADDR_WIDTH     (4),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_write_i (cmd_write),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .cmd_wstrb_i (cmd_wstrb),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .m_awaddr_o  (m_awaddr),
    .m_awvalid_o (m_awvalid),
    .m_awready_i (awready),
    .m_wdata_o   (m_wdata),
    .m_wstrb_o   (m_wstrb),
    .m_wvalid_o  (m_wvalid),
    .m_wready_i  (wready),
    .m_bvalid_i  (bvalid),
    .m_bready_o  (m_bready),
    .m_araddr_o  (m_araddr),
    .m_arvalid_o (m_arvalid),
    .m_arready_i (arready),
    .m_rdata_i   (rdata),
    .m_rvalid_i  (rvalid),
    .m_rready_o  (m_rready)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ctrl_outs();
    return {24'd0, cmd_ready, rsp_valid, rsp_err, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready};
  endfunction

  function automatic logic [31:0] data_outs();
    return rsp_rdata | m_wdata | {28'd0, m_awaddr | m_araddr | m_wstrb};
  endfunction

  // ---------------- register slave model ----------------
  logic [31:0] mem [4];
  logic        aw_got, w_got, rd_pend;
  logic [3:0]  aw_a, w_s;
  logic [31:0] w_d;
  logic        hold_b, stub, clr_mem;

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0;
      arready <= 1'b0; rvalid <= 1'b0; rdata  <= '0;
      aw_got  <= 1'b0; w_got  <= 1'b0; rd_pend <= 1'b0;
      aw_a    <= '0;   w_s    <= '0;   w_d     <= '0;
      if (clr_mem) for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      awready <= !stub && !aw_got && ($urandom_range(0, 2) != 0);
      wready  <= !stub && !w_got  && ($urandom_range(0, 2) != 0);
      if (m_awvalid && awready) begin aw_got <= 1'b1; aw_a <= m_awaddr; end
      if (m_wvalid && wready) begin w_got <= 1'b1; w_d <= m_wdata; w_s <= m_wstrb; end
      if (aw_got && w_got && !bvalid && !hold_b && ($urandom_range(0, 1) != 0)) begin
        for (int b = 0; b < 4; b++)
          if (w_s[b]) mem[aw_a[3:2]][8*b +: 8] <= w_d[8*b +: 8];
        aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b1;
      end
      if (bvalid && m_bready) bvalid <= 1'b0;
      arready <= !rd_pend && ($urandom_range(0, 2) != 0);
      if (m_arvalid && arready && !rd_pend) begin rd_pend <= 1'b1; rdata <= mem[m_araddr[3:2]]; end
      if (rd_pend && !rvalid && ($urandom_range(0, 1) != 0)) rvalid <= 1'b1;
      if (rvalid && m_rready) begin rvalid <= 1'b0; rd_pend <= 1'b0; end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        chk;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] shadow [4];
  int n_acc = 0, n_rsp = 0, n_aw = 0;

  // Monitor: accept bookkeeping, AW handshakes, response comparison.
  always @(negedge ACLK) begin
    if (ARESETn) begin
      if (cmd_valid && cmd_ready) begin
        n_acc++;
        chk_eq("accept_bus_idle", {29'd0, m_awvalid, m_wvalid, m_arvalid}, 32'd0);
      end
      if (m_awvalid && awready) n_aw++;
      if (rsp_valid) begin
        n_rsp++;
        chk_eq("rsp_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
        chk_eq("rsp_expected", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk_eq("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
          if (mon_e.chk) chk_eq("rsp_rdata", rsp_rdata, mon_e.rdata);
          else           chk_eq("rsp_rdata_xfree", {31'd0, $isunknown(rsp_rdata)}, 32'd0);
        end
      end
    end
  end

  // mode: 0 normal, 1 expect timeout error, 2 no response expected,
  //       3 read of unwritten register (data checked X-free only)
  task automatic issue(input logic wr, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic hold, input int mode);
    int k;
    exp_t e;
    @(posedge ACLK); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    k = 0;
    @(negedge ACLK);
    while (!cmd_ready && k < 300) begin @(negedge ACLK); k++; end
    chk_eq("accept_wait", {31'd0, cmd_ready}, 32'd1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge ACLK); #1;
    if (!hold) cmd_valid = 1'b0;
    e.chk = 1'b1; e.err = 1'b0; e.rdata = '0;
    if (mode == 1) begin
      e.err = 1'b1;
    end else if (wr) begin
      for (int b = 0; b < 4; b++) if (s[b]) shadow[a[3:2]][8*b +: 8] = d[8*b +: 8];
    end else begin
      e.rdata = shadow[a[3:2]];
      if (mode == 3) e.chk = 1'b0;
    end
    if (mode != 2) sb.push_back(e);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 500) begin @(negedge ACLK); k++; end
    chk_eq("drain", sb.size(), 32'd0);
    repeat (2) @(negedge ACLK);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base_acc, base_aw, base_rsp, k;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    hold_b = 1'b0; stub = 1'b0; clr_mem = 1'b1;
    for (int i = 0; i < 4; i++) shadow[i] = '0;

    // Reset state and first edge after release
    repeat (3) @(negedge ACLK);
    chk_eq("rst_ctrl", ctrl_outs(), 32'd0);
    chk_eq("rst_data", data_outs(), 32'd0);
    #2 ARESETn = 1'b1;
    #1 chk_eq("rdy_before_edge", {31'd0, cmd_ready}, 32'd0);
    @(posedge ACLK); #1;
    chk_eq("rdy_after_edge", {31'd0, cmd_ready}, 32'd1);
    clr_mem = 1'b0;

    // Read of an unwritten register
    issue(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 3);
    wait_drain();

    // Full write then read back
    issue(1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 1'b0, 0);
    issue(1'b0, 4'h4, 32'h0, 4'h0, 1'b0, 0);
    wait_drain();

    // Partial-strobe overwrite
    issue(1'b1, 4'h8, 32'hFFFFFFFF, 4'hF, 1'b0, 0);
    issue(1'b1, 4'h8, 32'h00001234, 4'h3, 1'b0, 0);
    issue(1'b0, 4'h8, 32'h0, 4'h0, 1'b0, 0);
    wait_drain();

    // cmd_valid held high across four writes
    base_acc = n_acc; base_aw = n_aw;
    for (int i = 0; i < 4; i++)
      issue(1'b1, 4'(i * 4), 32'hA000_0000 + 32'(i * 17), 4'(4'hF >> (i % 2)), i != 3, 0);
    wait_drain();
    chk_eq("hold_accepts", n_acc - base_acc, 32'd4);
    chk_eq("hold_aw_beats", n_aw - base_aw, 32'd4);
    for (int i = 0; i < 4; i++) issue(1'b0, 4'(i * 4), 32'h0, 4'h0, 1'b0, 0);
    wait_drain();

    // Async reset while waiting for the write response
    hold_b = 1'b1;
    issue(1'b1, 4'hC, 32'hA5A5A5A5, 4'hF, 1'b0, 2);
    k = 0;
    while (!m_bready && k < 100) begin @(negedge ACLK); k++; end
    chk_eq("in_wr_resp", {31'd0, m_bready}, 32'd1);
    base_rsp = n_rsp;
    #2 ARESETn = 1'b0;
    #1;
    chk_eq("mid_rst_ctrl", ctrl_outs(), 32'd0);
    chk_eq("mid_rst_data", data_outs(), 32'd0);
    sb.delete();
    hold_b = 1'b0;
    repeat (2) @(negedge ACLK);
    #2 ARESETn = 1'b1;
    #1 chk_eq("rel_rdy_before", {31'd0, cmd_ready}, 32'd0);
    @(posedge ACLK); #1;
    chk_eq("rel_rdy_after", {31'd0, cmd_ready}, 32'd1);
    repeat (5) @(negedge ACLK);
    chk_eq("no_rsp_after_abort", n_rsp - base_rsp, 32'd0);
    issue(1'b0, 4'h4, 32'h0, 4'h0, 1'b0, 0);
    wait_drain();

`ifdef AXIL_TIMEOUT_EN
    // Slave never accepts the write address: watchdog must end the access
    stub = 1'b1;
    issue(1'b1, 4'h0, 32'h12345678, 4'hF, 1'b0, 1);
    k = 0;
    do begin @(negedge ACLK); k++; end while (!rsp_valid && k < 100);
    chk_eq("tmo_latency", k, TMO);
    chk_eq("tmo_valids_low", {30'd0, m_awvalid, m_wvalid}, 32'd0);
    stub = 1'b0;
    wait_drain();
    issue(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 0);
    wait_drain();
`endif

    // One response per accepted command, except the one lost to reset
    chk_eq("rsp_per_cmd", n_rsp, n_acc - 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
